// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline hazard/stall sequencer; PIPE_STALL_PERF_CNT_EN builds the stall-cycle counter
module pipe_stall_ctrl #(
    parameter int MC_CYCLES = 32,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          ext_stall,
    input  logic          mc_start,
    input  logic          lu_hazard,
    input  logic          br_taken,
    output logic          pc_en,
    output logic          ifid_en,
    output logic          idex_en,
    output logic          exmem_en,
    output logic          memwb_en,
    output logic          ifid_flush,
    output logic          idex_bubble,
    output logic          exmem_bubble,
    output logic          mc_busy,
    output logic [CW-1:0] mc_cnt,
    output logic [31:0]   stall_cnt
);
    typedef enum logic {RUN, MC_WAIT} state_t;

    state_t        state, next_state;
    logic [CW-1:0] next_cnt;
    logic          hold;
    logic [4:0]    en;
    logic [2:0]    bub;

    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            state  <= RUN;
            mc_cnt <= '0;
        end else if (!ext_stall) begin
            state  <= next_state;
            mc_cnt <= next_cnt;
        end

    // hold = multi-cycle op occupies EX this cycle (release cycle excluded)
    always_comb begin
        hold       = (state == RUN) ? mc_start : (mc_cnt != '0);
        next_state = hold ? MC_WAIT : RUN;
        next_cnt   = (state == RUN) ? (mc_start ? CW'(MC_CYCLES - 2) : '0)
                                    : (hold ? mc_cnt - CW'(1) : '0);
        en         = (clr || ext_stall) ? 5'b00000 : hold ? 5'b00011 : lu_hazard ? 5'b00111 : 5'b11111;
        bub        = (clr || ext_stall) ? 3'b000 : hold ? 3'b001 : lu_hazard ? 3'b010 : {br_taken, 2'b00};
    end

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en;
    assign {ifid_flush, idex_bubble, exmem_bubble}       = bub;
    assign mc_busy = (state == MC_WAIT);

`ifdef PIPE_STALL_PERF_CNT_EN
    always_ff @(posedge clk or posedge clr)
        if (clr)
            stall_cnt <= '0;
        else if (!pc_en)
            stall_cnt <= stall_cnt + 32'd1;
`else
    assign stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
    logic clk = 0, clr = 1;
    logic ext_stall = 1, mc_start4 = 1, mc_start8 = 1, lu_hazard = 1, br_taken = 1;
    logic pc4, ifid4, idex4, exmem4, memwb4, fl4, ib4, eb4, busy4;
    logic pc8, ifid8, idex8, exmem8, memwb8, fl8, ib8, eb8, busy8;
    logic [7:0] cnt4, cnt8;
    logic [31:0] sc4, sc8;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MC_CYCLES(4), .CW(8)) u4 (
        .clk(clk), .clr(clr), .ext_stall(ext_stall), .mc_start(mc_start4),
        .lu_hazard(lu_hazard), .br_taken(br_taken), .pc_en(pc4), .ifid_en(ifid4),
        .idex_en(idex4), .exmem_en(exmem4), .memwb_en(memwb4), .ifid_flush(fl4),
        .idex_bubble(ib4), .exmem_bubble(eb4), .mc_busy(busy4), .mc_cnt(cnt4), .stall_cnt(sc4));

    pipe_stall_ctrl #(.MC_CYCLES(8), .CW(8)) u8 (
        .clk(clk), .clr(clr), .ext_stall(ext_stall), .mc_start(mc_start8),
        .lu_hazard(lu_hazard), .br_taken(br_taken), .pc_en(pc8), .ifid_en(ifid8),
        .idex_en(idex8), .exmem_en(exmem8), .memwb_en(memwb8), .ifid_flush(fl8),
        .idex_bubble(ib8), .exmem_bubble(eb8), .mc_busy(busy8), .mc_cnt(cnt8), .stall_cnt(sc8));

    wire [4:0] en4 = {pc4, ifid4, idex4, exmem4, memwb4};
    wire [2:0] bb4 = {fl4, ib4, eb4};
    wire [4:0] en8 = {pc8, ifid8, idex8, exmem8, memwb8};

`ifdef PIPE_STALL_PERF_CNT_EN
    localparam bit PERF = 1;
`else
    localparam bit PERF = 0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic st4(input string tag, input logic [4:0] e, input logic [2:0] b, input logic busy, input logic [7:0] c);
        #1;
        check({tag, ".en"}, 32'(en4), 32'(e));
        check({tag, ".bub"}, 32'(bb4), 32'(b));
        check({tag, ".busy"}, 32'(busy4), 32'(busy));
        check({tag, ".cnt"}, 32'(cnt4), 32'(c));
    endtask

    initial begin
        #3;
        st4("rst_all_in", 5'h00, 3'b000, 0, 0);
        check("rst_en8", 32'(en8), 0);
        check("rst_sc4", sc4, 0);
        cyc();
        {ext_stall, mc_start4, mc_start8, lu_hazard, br_taken} = '0;
        clr = 0;
        st4("rel_idle", 5'h1f, 3'b000, 0, 0);
        cyc();
        st4("rel_next", 5'h1f, 3'b000, 0, 0);
        // multi-cycle op with MC_CYCLES=4
        mc_start4 = 1;
        st4("mc_start", 5'b00011, 3'b001, 0, 0);
        cyc(); mc_start4 = 0;
        st4("mc_w2", 5'b00011, 3'b001, 1, 2);
        cyc(); mc_start4 = 1;
        st4("mc_w1_ignore_start", 5'b00011, 3'b001, 1, 1);
        cyc(); mc_start4 = 0; br_taken = 1;
        st4("mc_release_br", 5'h1f, 3'b100, 1, 0);
        cyc(); br_taken = 0;
        st4("mc_after", 5'h1f, 3'b000, 0, 0);
        // ext_stall beats mc_start in RUN
        cyc(); ext_stall = 1; mc_start4 = 1;
        st4("xs_vs_start", 5'h00, 3'b000, 0, 0);
        cyc(); ext_stall = 0; mc_start4 = 0;
        st4("xs_start_dropped", 5'h1f, 3'b000, 0, 0);
        // ext_stall while MC_WAIT with mc_cnt=1
        cyc(); mc_start4 = 1;
        cyc(); mc_start4 = 0;
        st4("xs_w2", 5'b00011, 3'b001, 1, 2);
        cyc(); ext_stall = 1;
        for (int i = 0; i < 5; i++) begin
            st4($sformatf("xs_hold%0d", i), 5'h00, 3'b000, 1, 1);
            cyc();
        end
        ext_stall = 0;
        st4("xs_drop", 5'b00011, 3'b001, 1, 1);
        cyc();
        st4("xs_release", 5'h1f, 3'b000, 1, 0);
        cyc(); lu_hazard = 1; br_taken = 1;
        st4("lu_br", 5'b00111, 3'b010, 0, 0);
        cyc(); lu_hazard = 0;
        st4("br_only", 5'h1f, 3'b100, 0, 0);
        cyc(); br_taken = 0;
        st4("idle", 5'h1f, 3'b000, 0, 0);
        // clr mid-op on the MC_CYCLES=8 instance
        mc_start8 = 1;
        cyc(); mc_start8 = 0;
        #1 check("u8_cnt6", 32'(cnt8), 6);
        cyc();
        #1 check("u8_cnt5", 32'(cnt8), 5);
        check("u8_busy", 32'(busy8), 1);
        clr = 1;
        #1;
        check("u8_clr_cnt", 32'(cnt8), 0);
        check("u8_clr_busy", 32'(busy8), 0);
        check("u8_clr_en", 32'(en8), 0);
        cyc(); clr = 0;
        #1 check("u8_post_clr_en", 32'(en8), 32'h1f);
        check("sc_after_clr", sc4, 0);
        // stall counter: 10 load-use cycles
        lu_hazard = 1;
        repeat (10) cyc();
        lu_hazard = 0;
        #1;
        check("sc4_10", sc4, PERF ? 32'd10 : 32'd0);
        check("sc8_10", sc8, PERF ? 32'd10 : 32'd0);
`ifdef PIPE_STALL_PERF_CNT_EN
        cyc();
        force u4.stall_cnt = 32'hFFFF_FFFF;
        #1 release u4.stall_cnt;
        lu_hazard = 1;
        cyc(); lu_hazard = 0;
        #1 check("sc4_wrap", sc4, 32'd0);
`endif
        cyc();
        #1 check("sc4_final", sc4, PERF ? 32'd0 : 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
